// File: rtl/trainerror_handshake_wrapper.sv
// trainerror_handshake_wrapper
// Runs the TRAINERROR entry handshake over the sideband. A TX FSM sends the
// local request and waits for the partner's response. An RX FSM waits for the
// partner's request and answers it. Both share one registered transmit strobe.
// Optional feature macro: TRAINERROR_HS_TIMEOUT_EN adds o_timeout and a
// handshake cycle counter. When the counter expires it freezes both FSMs.
//
// Handshake semantics: o_tx_msg_valid is a one-cycle strobe. While it is high,
// o_encoded_SB_msg carries the code to send; otherwise o_encoded_SB_msg is 0.
// A strobe is only produced when i_SB_Busy was low in the deciding cycle.
// There is no ready return path.
module trainerror_handshake_wrapper #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int REQ_CODE       = 14,
  parameter int RESP_CODE      = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_trainerror_en,
  input  logic                    i_SB_Busy,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_TRAINERROR_HS_end
`ifdef TRAINERROR_HS_TIMEOUT_EN
  ,output logic                   o_timeout
`endif
);

  localparam logic [SB_MSG_WIDTH-1:0] REQ_C  = SB_MSG_WIDTH'(REQ_CODE);
  localparam logic [SB_MSG_WIDTH-1:0] RESP_C = SB_MSG_WIDTH'(RESP_CODE);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_END  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_WAIT_REQ = 2'd1,
    RX_RESP     = 2'd2,
    RX_END      = 2'd3
  } rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic      req_pending, req_pending_next;
  logic      msg_is_req, msg_is_resp;
  logic      resp_due, can_send, send_req, send_resp;
  logic      frozen;

  assign msg_is_req  = (i_decoded_SB_msg == REQ_C);
  assign msg_is_resp = (i_decoded_SB_msg == RESP_C);

`ifdef TRAINERROR_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] hs_cnt;

  // Count enabled, unfinished cycles; expire once and hold until disable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_cnt    <= '0;
      o_timeout <= 1'b0;
    end else if (!i_trainerror_en) begin
      hs_cnt    <= '0;
      o_timeout <= 1'b0;
    end else if (!o_timeout && !(tx_state == TX_END && rx_state == RX_END)) begin
      hs_cnt <= hs_cnt + 1'b1;
      if (hs_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) o_timeout <= 1'b1;
    end
  end

  assign frozen = o_timeout;
`else
  assign frozen = 1'b0;
`endif

  // Transmit arbitration: the response wins over the request. A partner
  // request that is just arriving already counts as an owed response. One
  // idle cycle is always left after each strobe.
  always_comb begin
    resp_due  = (rx_state == RX_RESP) || (rx_state == RX_WAIT_REQ && msg_is_req);
    can_send  = i_trainerror_en && !i_SB_Busy && !o_tx_msg_valid && !frozen;
    send_resp = can_send && (rx_state == RX_RESP);
    send_req  = can_send && (tx_state == TX_REQ) && req_pending && !resp_due;
  end

  // TX next state: send one request, then wait for the partner's response
  always_comb begin
    tx_next          = tx_state;
    req_pending_next = req_pending;
    if (!i_trainerror_en) begin
      tx_next          = TX_IDLE;
      req_pending_next = 1'b0;
    end else if (!frozen) begin
      case (tx_state)
        TX_IDLE: begin
          tx_next          = TX_REQ;
          req_pending_next = 1'b1;
        end
        TX_REQ: begin
          if (send_req) req_pending_next = 1'b0;
          // A response seen before our request has gone out is ignored
          if (!req_pending && msg_is_resp) tx_next = TX_END;
        end
        TX_END:  tx_next = TX_END;
        default: tx_next = TX_IDLE;
      endcase
    end
  end

  // RX next state: wait for the partner's request, then answer it once
  always_comb begin
    rx_next = rx_state;
    if (!i_trainerror_en) begin
      rx_next = RX_IDLE;
    end else if (!frozen) begin
      case (rx_state)
        RX_IDLE:     rx_next = RX_WAIT_REQ;
        RX_WAIT_REQ: if (msg_is_req) rx_next = RX_RESP;
        RX_RESP:     if (send_resp) rx_next = RX_END;
        RX_END:      rx_next = RX_END;
        default:     rx_next = RX_IDLE;
      endcase
    end
  end

  // State, pending flag and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state            <= TX_IDLE;
      rx_state            <= RX_IDLE;
      req_pending         <= 1'b0;
      o_tx_msg_valid      <= 1'b0;
      o_encoded_SB_msg    <= '0;
      o_TRAINERROR_HS_end <= 1'b0;
    end else begin
      tx_state            <= tx_next;
      rx_state            <= rx_next;
      req_pending         <= req_pending_next;
      o_tx_msg_valid      <= send_resp || send_req;
      o_encoded_SB_msg    <= send_resp ? RESP_C : (send_req ? REQ_C : '0);
      // Registered from next state so it tracks (TX==END && RX==END) exactly
      o_TRAINERROR_HS_end <= (tx_next == TX_END) && (rx_next == RX_END);
    end
  end

endmodule

// File: tb/tb_trainerror_handshake_wrapper.sv
// tb_trainerror_handshake_wrapper
// Directed scenarios plus randomized partner traffic, checked against a
// message-level model of the handshake.
module tb_trainerror_handshake_wrapper;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       busy;
  logic [3:0] dmsg;
  logic [3:0] emsg;
  logic       valid;
  logic       hs_end;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;

  logic [3:0] exp_q[$];

  // Model: message-level bookkeeping of the handshake
  bit         m_active, m_req_todo, m_resp_owed, m_resp_done, m_resp_rcvd;
  bit         m_last_valid;
  logic       m_valid;
  logic [3:0] m_msg;
  logic       m_end;

  trainerror_handshake_wrapper dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_trainerror_en    (en),
    .i_SB_Busy          (busy),
    .i_decoded_SB_msg   (dmsg),
    .o_encoded_SB_msg   (emsg),
    .o_tx_msg_valid     (valid),
    .o_TRAINERROR_HS_end(hs_end)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active     = 0;
    m_req_todo   = 0;
    m_resp_owed  = 0;
    m_resp_done  = 0;
    m_resp_rcvd  = 0;
    m_last_valid = 0;
    m_valid      = 1'b0;
    m_msg        = 4'd0;
    m_end        = 1'b0;
  endfunction

  // One clock edge of the handshake rules, using the inputs seen at the edge
  function automatic void model_step();
    bit owe, inc_req, can, s_resp, s_req;
    if (!en) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      m_active   = 1;
      m_req_todo = 1;
      m_valid    = 1'b0;
      m_msg      = 4'd0;
      m_end      = 1'b0;
      m_last_valid = 0;
      return;
    end
    owe     = m_resp_owed && !m_resp_done;
    inc_req = !m_resp_owed && (dmsg == 4'd14);
    can     = !busy && !m_last_valid;
    s_resp  = can && owe;
    s_req   = can && !owe && m_req_todo && !inc_req;
    if (!m_req_todo && dmsg == 4'd15) m_resp_rcvd = 1;
    if (dmsg == 4'd14) m_resp_owed = 1;
    if (s_resp) m_resp_done = 1;
    if (s_req)  m_req_todo = 0;
    m_valid      = s_resp | s_req;
    m_msg        = s_resp ? 4'd15 : (s_req ? 4'd14 : 4'd0);
    m_last_valid = m_valid;
    if (m_valid) exp_q.push_back(m_msg);
    m_end = m_resp_rcvd && m_resp_done;
  endfunction

  // Driver: apply inputs at negedge, step model at posedge, settle
  task automatic cycle(input logic e, input logic b, input logic [3:0] m);
    @(negedge clk);
    en = e; busy = b; dmsg = m;
    @(posedge clk);
    model_step();
    #1;
    if (valid) strobe_cnt++;
  endtask

  // Driver: hold inputs until a strobe appears or the budget runs out
  task automatic wait_strobe(input logic e, input logic b, input logic [3:0] m,
                             input int budget, output bit found,
                             output logic [3:0] code, output int waited);
    found = 0; code = 4'd0; waited = 0;
    while (!found && waited < budget) begin
      cycle(e, b, m);
      waited++;
      if (valid) begin
        found = 1;
        code  = emsg;
      end
    end
  endtask

  task automatic go_idle();
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    bit f; logic [3:0] c; int w;
    rst = 1'b1; en = 1'b1; busy = 1'b0; dmsg = 4'd14;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (valid !== 1'b0 || emsg !== 4'd0 || hs_end !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: valid=%b msg=%0d end=%b expected 0/0/0", valid, emsg, hs_end);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; dmsg = 4'd0;
    model_reset();
    go_idle();
    // Reach END, then reset asynchronously between clock edges
    wait_strobe(1'b1, 1'b0, 4'd14, 10, f, c, w);
    wait_strobe(1'b1, 1'b0, 4'd14, 10, f, c, w);
    cycle(1'b1, 1'b0, 4'd15);
    n_cmp++;
    if (hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_end: end=%b expected 1", hs_end);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || emsg !== 4'd0 || hs_end !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: valid=%b msg=%0d end=%b expected 0/0/0", valid, emsg, hs_end);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; dmsg = 4'd0;
    model_reset();
    go_idle();
  endtask

  task automatic test_basic();
    bit f; logic [3:0] c; int w; int extra;
    go_idle();
    wait_strobe(1'b1, 1'b0, 4'd0, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14) begin
      n_err++;
      $display("FAIL basic_req: found=%0d code=%0d expected code 14", f, c);
    end
    extra = 0;
    repeat (6) begin
      cycle(1'b1, 1'b0, 4'd0);
      if (valid) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL basic_req_once: extra strobes=%0d expected 0", extra);
    end
    wait_strobe(1'b1, 1'b0, 4'd14, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd15) begin
      n_err++;
      $display("FAIL basic_resp: found=%0d code=%0d expected code 15", f, c);
    end
    cycle(1'b1, 1'b0, 4'd15);
    n_cmp++;
    if (hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL basic_end: end=%b expected 1", hs_end);
    end
    repeat (3) cycle(1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (hs_end !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end_hold: end=%b valid=%b expected 1/0", hs_end, valid);
    end
  endtask

  task automatic test_resp_first();
    bit f; logic [3:0] c; int w;
    go_idle();
    strobe_cnt = 0;
    wait_strobe(1'b1, 1'b0, 4'd15, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14) begin
      n_err++;
      $display("FAIL rf_req: found=%0d code=%0d expected code 14", f, c);
    end
    cycle(1'b1, 1'b0, 4'd15);
    cycle(1'b1, 1'b0, 4'd0);
    wait_strobe(1'b1, 1'b0, 4'd14, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd15 || hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL rf_resp: found=%0d code=%0d end=%b expected 15/1", f, c, hs_end);
    end
    repeat (4) cycle(1'b1, 1'b0, 4'd14);
    n_cmp++;
    if (strobe_cnt !== 2 || hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL rf_total: strobes=%0d end=%b expected 2/1", strobe_cnt, hs_end);
    end
  endtask

  task automatic test_req_present();
    bit f; logic [3:0] c; int w;
    go_idle();
    cycle(1'b0, 1'b0, 4'd14);
    wait_strobe(1'b1, 1'b0, 4'd14, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd15) begin
      n_err++;
      $display("FAIL rp_first: found=%0d code=%0d expected code 15", f, c);
    end
    wait_strobe(1'b1, 1'b0, 4'd14, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14 || w < 2) begin
      n_err++;
      $display("FAIL rp_second: found=%0d code=%0d gap=%0d expected 14 with gap>=2", f, c, w);
    end
    cycle(1'b1, 1'b0, 4'd15);
    n_cmp++;
    if (hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL rp_end: end=%b expected 1", hs_end);
    end
  endtask

  task automatic test_busy();
    bit f; logic [3:0] c; int w; int during;
    go_idle();
    during = 0;
    repeat (5) begin
      cycle(1'b1, 1'b1, 4'd0);
      if (valid) during++;
    end
    n_cmp++;
    if (during !== 0) begin
      n_err++;
      $display("FAIL busy_hold: strobes during busy=%0d expected 0", during);
    end
    wait_strobe(1'b1, 1'b0, 4'd0, 2, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14) begin
      n_err++;
      $display("FAIL busy_release: found=%0d code=%0d expected 14 within 2", f, c);
    end
  endtask

  task automatic test_disable();
    bit f; logic [3:0] c; int w;
    go_idle();
    cycle(1'b1, 1'b1, 4'd0);
    cycle(1'b1, 1'b1, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (valid !== 1'b0 || hs_end !== 1'b0) begin
      n_err++;
      $display("FAIL dis_mid: valid=%b end=%b expected 0/0", valid, hs_end);
    end
    wait_strobe(1'b1, 1'b0, 4'd0, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14) begin
      n_err++;
      $display("FAIL dis_restart: found=%0d code=%0d expected 14", f, c);
    end
    wait_strobe(1'b1, 1'b0, 4'd14, 8, f, c, w);
    cycle(1'b1, 1'b0, 4'd15);
    n_cmp++;
    if (hs_end !== 1'b1) begin
      n_err++;
      $display("FAIL dis_reach_end: end=%b expected 1", hs_end);
    end
    cycle(1'b0, 1'b0, 4'd15);
    n_cmp++;
    if (valid !== 1'b0 || hs_end !== 1'b0) begin
      n_err++;
      $display("FAIL dis_end: valid=%b end=%b expected 0/0", valid, hs_end);
    end
    wait_strobe(1'b1, 1'b0, 4'd0, 8, f, c, w);
    n_cmp++;
    if (!f || c !== 4'd14) begin
      n_err++;
      $display("FAIL dis_fresh: found=%0d code=%0d expected 14", f, c);
    end
  endtask

  task automatic test_random();
    logic [3:0] pick[4];
    logic [3:0] cur, got;
    logic       e;
    pick[0] = 4'd0; pick[1] = 4'd14; pick[2] = 4'd15; pick[3] = 4'd9;
    go_idle();
    exp_q.delete();
    for (int t = 0; t < 25; t++) begin
      cur = 4'd0;
      repeat ($urandom_range(1, 2)) cycle(1'b0, 1'b0, 4'd0);
      for (int k = 0; k < $urandom_range(25, 55); k++) begin
        if ($urandom_range(0, 3) == 0) cur = pick[$urandom_range(0, 3)];
        e = ($urandom_range(0, 39) != 0);
        cycle(e, ($urandom_range(0, 2) == 0), cur);
        n_cmp++;
        if (valid !== m_valid || hs_end !== m_end || (!valid && emsg !== 4'd0)) begin
          n_err++;
          $display("FAIL rand_cycle t=%0d k=%0d: valid=%b end=%b msg=%0d expected valid=%b end=%b",
                   t, k, valid, hs_end, emsg, m_valid, m_end);
        end
        if (valid) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rand_code t=%0d: got %0d, expected no strobe", t, emsg);
          end else begin
            got = exp_q.pop_front();
            if (emsg !== got) begin
              n_err++;
              $display("FAIL rand_code t=%0d: got %0d expected %0d", t, emsg, got);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_leftover: %0d expected strobes never seen", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; busy = 1'b0; dmsg = 4'd0;
    model_reset();
    test_reset();
    test_basic();
    test_resp_first();
    test_req_present();
    test_busy();
    test_disable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
